// File: rtl/ad9833_sweep_ctrl.sv
// rtl/ad9833_sweep_ctrl.sv - AD9833 frequency sweep sequencer; define SWEEP_TRIANGLE_EN for up/down sweeps
module ad9833_sweep_ctrl #(
    parameter int DWELL_W = 24,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [27:0]        ftw_start,
    input  logic [27:0]        ftw_step,
    input  logic [STEP_W-1:0]  num_steps,
    input  logic [DWELL_W-1:0] dwell_clks,
    output logic               wr_go,
    output logic [15:0]        wr_word,
    input  logic               wr_ack,
    output logic               busy,
    output logic [27:0]        ftw_cur,
    output logic [STEP_W-1:0]  step_idx,
    output logic               sweep_done
);

    typedef enum logic [2:0] {
        IDLE, INIT_CTRL, LOAD_LSW, LOAD_MSW, RUN_CTRL, DWELL, NEXT, FINISH
    } state_t;

    localparam logic [15:0] CTRL_RESET = 16'h2100;
    localparam logic [15:0] CTRL_RUN   = 16'h2000;

    state_t               state, state_n;
    logic                 go_q, go_n;
    logic [15:0]          word_q, word_n;
    logic [27:0]          ftw_q, ftw_n;
    logic [STEP_W-1:0]    idx_q, idx_n;
    logic                 done_q, done_n;
    logic                 stop_pend, pend_n;
    logic                 first_pt, first_n;
    logic                 dir_down, dir_n;
    logic [DWELL_W-1:0]   dwell_cnt, cnt_n;
    logic                 cont_r, cont_n;
    logic [27:0]          fs_r, fs_n;
    logic [27:0]          fst_r, fst_n;
    logic [STEP_W-1:0]    last_r, last_n;
    logic [DWELL_W-1:0]   dw_r, dw_n;
    logic                 stop_req;

    function automatic logic [15:0] lsw_word(input logic [27:0] f);
        return {2'b01, f[13:0]};
    endfunction

    function automatic logic [15:0] msw_word(input logic [27:0] f);
        return {2'b01, f[27:14]};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            go_q      <= 1'b0;
            word_q    <= '0;
            ftw_q     <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            stop_pend <= 1'b0;
            first_pt  <= 1'b0;
            dir_down  <= 1'b0;
            dwell_cnt <= '0;
            cont_r    <= 1'b0;
            fs_r      <= '0;
            fst_r     <= '0;
            last_r    <= '0;
            dw_r      <= '0;
        end else begin
            state     <= state_n;
            go_q      <= go_n;
            word_q    <= word_n;
            ftw_q     <= ftw_n;
            idx_q     <= idx_n;
            done_q    <= done_n;
            stop_pend <= pend_n;
            first_pt  <= first_n;
            dir_down  <= dir_n;
            dwell_cnt <= cnt_n;
            cont_r    <= cont_n;
            fs_r      <= fs_n;
            fst_r     <= fst_n;
            last_r    <= last_n;
            dw_r      <= dw_n;
        end
    end

    always_comb begin
        state_n  = state;
        go_n     = go_q;
        word_n   = word_q;
        ftw_n    = ftw_q;
        idx_n    = idx_q;
        done_n   = 1'b0;
        pend_n   = stop_pend;
        first_n  = first_pt;
        dir_n    = dir_down;
        cnt_n    = dwell_cnt;
        cont_n   = cont_r;
        fs_n     = fs_r;
        fst_n    = fst_r;
        last_n   = last_r;
        dw_n     = dw_r;
        stop_req = stop | stop_pend;

        if (state != IDLE && state != FINISH && stop)
            pend_n = 1'b1;

        case (state)
            IDLE: begin
                pend_n = 1'b0;
                if (start && !stop) begin
                    cont_n  = continuous;
                    fs_n    = ftw_start;
                    fst_n   = ftw_step;
                    last_n  = (num_steps == '0) ? '0 : num_steps - 1'b1;
                    dw_n    = (dwell_clks == '0) ? DWELL_W'(1) : dwell_clks;
                    ftw_n   = ftw_start;
                    idx_n   = '0;
                    first_n = 1'b1;
                    dir_n   = 1'b0;
                    go_n    = 1'b1;
                    word_n  = CTRL_RESET;
                    state_n = INIT_CTRL;
                end
            end

            INIT_CTRL, LOAD_LSW, LOAD_MSW, RUN_CTRL, FINISH: begin
                if (!go_q) begin
                    // One idle cycle after each ack before the next word goes out
                    go_n = 1'b1;
                    case (state)
                        LOAD_LSW: word_n = lsw_word(ftw_q);
                        LOAD_MSW: word_n = msw_word(ftw_q);
                        RUN_CTRL: word_n = CTRL_RUN;
                        default:  word_n = CTRL_RESET;
                    endcase
                end else if (wr_ack) begin
                    go_n = 1'b0;
                    case (state)
                        INIT_CTRL: state_n = stop_req ? FINISH : LOAD_LSW;
                        LOAD_LSW:  state_n = stop_req ? FINISH : LOAD_MSW;
                        LOAD_MSW: begin
                            first_n = 1'b0;
                            if (stop_req)
                                state_n = FINISH;
                            else if (first_pt)
                                state_n = RUN_CTRL;
                            else begin
                                state_n = DWELL;
                                cnt_n   = dw_r - 1'b1;
                            end
                        end
                        RUN_CTRL: begin
                            if (stop_req)
                                state_n = FINISH;
                            else begin
                                state_n = DWELL;
                                cnt_n   = dw_r - 1'b1;
                            end
                        end
                        default: begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                            pend_n  = 1'b0;
                        end
                    endcase
                end
            end

            DWELL: begin
                if (stop_req)
                    state_n = FINISH;
                else if (dwell_cnt == '0)
                    state_n = NEXT;
                else
                    cnt_n = dwell_cnt - 1'b1;
            end

            NEXT: begin
                state_n = FINISH;
                if (!stop_req) begin
`ifdef SWEEP_TRIANGLE_EN
                    if (!dir_down) begin
                        if (idx_q < last_r) begin
                            idx_n   = idx_q + 1'b1;
                            ftw_n   = ftw_q + fst_r;
                            state_n = LOAD_LSW;
                        end else if (last_r != '0) begin
                            dir_n   = 1'b1;
                            idx_n   = idx_q - 1'b1;
                            ftw_n   = ftw_q - fst_r;
                            state_n = LOAD_LSW;
                        end else if (cont_r) begin
                            state_n = LOAD_LSW;
                        end
                    end else begin
                        if (idx_q != '0) begin
                            idx_n   = idx_q - 1'b1;
                            ftw_n   = ftw_q - fst_r;
                            state_n = LOAD_LSW;
                        end else if (cont_r) begin
                            dir_n   = 1'b0;
                            idx_n   = idx_q + 1'b1;
                            ftw_n   = ftw_q + fst_r;
                            state_n = LOAD_LSW;
                        end
                    end
`else
                    if (idx_q < last_r) begin
                        idx_n   = idx_q + 1'b1;
                        ftw_n   = ftw_q + fst_r;
                        state_n = LOAD_LSW;
                    end else if (cont_r) begin
                        idx_n   = '0;
                        ftw_n   = fs_r;
                        state_n = LOAD_LSW;
                    end
`endif
                end
                // The line has been idle through the dwell, so the LSW can go out at once
                if (state_n == LOAD_LSW) begin
                    go_n   = 1'b1;
                    word_n = lsw_word(ftw_n);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign wr_go      = go_q;
    assign wr_word    = word_q;
    assign busy       = (state != IDLE);
    assign ftw_cur    = ftw_q;
    assign step_idx   = idx_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_ad9833_sweep_ctrl.sv
// tb/tb_ad9833_sweep_ctrl.sv - randomized self-checking bench for ad9833_sweep_ctrl
module tb_ad9833_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, continuous, wr_ack;
    logic [27:0] ftw_start, ftw_step;
    logic [15:0] num_steps;
    logic [23:0] dwell_clks;
    logic        wr_go, busy, sweep_done;
    logic [15:0] wr_word;
    logic [27:0] ftw_cur;
    logic [15:0] step_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] cap_word[$];
    logic [27:0] cap_ftw[$];
    logic [15:0] cap_idx[$];
    int          cap_gap[$];
    int          n_acked = 0;
    int          low_cnt = 0;
    int          ack_min = 2;
    int          ack_max = 5;

    ad9833_sweep_ctrl #(.DWELL_W(24), .STEP_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .ftw_start  (ftw_start),
        .ftw_step   (ftw_step),
        .num_steps  (num_steps),
        .dwell_clks (dwell_clks),
        .wr_go      (wr_go),
        .wr_word    (wr_word),
        .wr_ack     (wr_ack),
        .busy       (busy),
        .ftw_cur    (ftw_cur),
        .step_idx   (step_idx),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    // Word transmitter model: captures each word, holds it for a random time, then acks
    initial begin
        logic [15:0] w;
        int          d;
        bit          bad;
        wr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && wr_go === 1'b1) begin
                w = wr_word;
                cap_word.push_back(wr_word);
                cap_ftw.push_back(ftw_cur);
                cap_idx.push_back(step_idx);
                cap_gap.push_back(low_cnt);
                d   = $urandom_range(ack_min, ack_max);
                bad = 1'b0;
                repeat (d - 1) begin
                    @(negedge clk);
                    if (rst_n === 1'b1 && (wr_go !== 1'b1 || wr_word !== w)) bad = 1'b1;
                end
                n_checks++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL handshake_stable: word %h not held with wr_go until ack", w);
                end
                wr_ack = 1'b1;
                @(negedge clk);
                wr_ack = 1'b0;
                n_acked++;
                if (rst_n === 1'b1) begin
                    n_checks++;
                    if (wr_go !== 1'b0) begin
                        n_fail++;
                        $display("FAIL go_drop: wr_go=%b after ack, required 0", wr_go);
                    end
                end
                low_cnt = 1;
            end else begin
                low_cnt++;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One complete sweep: drive, let it run (optionally stopped), compare with the model
    task automatic do_sweep(input logic [27:0] s, input logic [27:0] st, input logic [15:0] n,
                            input logic [23:0] d, input bit cont, input int smode,
                            input int sk, input int sdel, input string name);
        logic [15:0] ew[$];
        bit          ek[$];
        logic [27:0] ef[$];
        logic [15:0] ei[$];
        int          eg[$];
        int          neff, deff, maxw, total, idx, per, cyc, dones, sdone;
        logic [27:0] f;

        neff = (n == 0) ? 1 : int'(n);
        deff = (d == 0) ? 1 : int'(d);
        maxw = cont ? sk + 8 : 1 << 30;
`ifdef SWEEP_TRIANGLE_EN
        total = 2 * neff - 1;
`else
        total = neff;
`endif
        ew.push_back(16'h2100); ek.push_back(0); ef.push_back('0); ei.push_back('0); eg.push_back(-1);
        for (int j = 0; ew.size() < maxw; j++) begin
            if (!cont && j >= total) begin
                ew.push_back(16'h2100); ek.push_back(0); ef.push_back('0); ei.push_back('0); eg.push_back(-1);
                break;
            end
`ifdef SWEEP_TRIANGLE_EN
            per = 2 * (neff - 1);
            if (neff == 1) idx = 0;
            else idx = ((j % per) < neff) ? (j % per) : per - (j % per);
`else
            per = neff;
            idx = j % per;
`endif
            f = s + 28'(idx) * st;
            ew.push_back({2'b01, f[13:0]});  ek.push_back(1); ef.push_back(f);
            ei.push_back(16'(idx));          eg.push_back(j == 0 ? -1 : deff + 1);
            ew.push_back({2'b01, f[27:14]}); ek.push_back(0); ef.push_back('0); ei.push_back('0); eg.push_back(-1);
            if (j == 0) begin
                ew.push_back(16'h2000); ek.push_back(0); ef.push_back('0); ei.push_back('0); eg.push_back(-1);
            end
        end
        if (smode != 0 && sk < ew.size()) begin
            while (ew.size() > sk) begin
                void'(ew.pop_back()); void'(ek.pop_back()); void'(ef.pop_back());
                void'(ei.pop_back()); void'(eg.pop_back());
            end
            ew.push_back(16'h2100); ek.push_back(0); ef.push_back('0); ei.push_back('0); eg.push_back(-1);
        end

        cap_word.delete(); cap_ftw.delete(); cap_idx.delete(); cap_gap.delete();
        n_acked = 0;
        ftw_start = s; ftw_step = st; num_steps = n; dwell_clks = d; continuous = cont;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (wr_go !== 1'b1 || wr_word !== 16'h2100 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start_resp: go=%b word=%h busy=%b, required 1 2100 1", name, wr_go, wr_word, busy);
        end
        ftw_start = 28'($urandom); ftw_step = 28'($urandom);
        num_steps = 16'($urandom_range(0, 7)); dwell_clks = 24'($urandom_range(0, 9));
        continuous = ~cont;

        cyc = 0; dones = 0; sdone = 0;
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            stop  = 1'b0;
            if (sweep_done === 1'b1) dones++;
            if (busy !== 1'b1) break;
            if ($urandom_range(0, 15) == 0) start = 1'b1;
            if (smode == 1 && sdone == 0 && cap_word.size() >= sk) begin
                if (sdel == 0) begin stop = 1'b1; sdone = 1; end
                else sdel--;
            end
            if (smode == 2 && sdone == 0 && n_acked >= sk) begin
                stop = 1'b1; sdone = 1;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s timeout: busy still %b after %0d cycles", name, busy, cyc);
        end
        n_checks++;
        if (dones != 1 || wr_go !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: sweep_done seen %0d times, go=%b; required 1, 0", name, dones, wr_go);
        end
        @(negedge clk);
        n_checks++;
        if (sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: sweep_done=%b one cycle later, required 0", name, sweep_done);
        end
        n_checks++;
        if (cap_word.size() != ew.size()) begin
            n_fail++;
            $display("FAIL %s word_count: %0d words, required %0d", name, cap_word.size(), ew.size());
        end
        for (int i = 0; i < ew.size() && i < cap_word.size(); i++) begin
            n_checks++;
            if (cap_word[i] !== ew[i]) begin
                n_fail++;
                $display("FAIL %s word[%0d]: %h, required %h", name, i, cap_word[i], ew[i]);
            end
            if (ek[i]) begin
                n_checks++;
                if (cap_ftw[i] !== ef[i] || cap_idx[i] !== ei[i]) begin
                    n_fail++;
                    $display("FAIL %s point[%0d]: ftw=%h idx=%0d, required ftw=%h idx=%0d",
                             name, i, cap_ftw[i], cap_idx[i], ef[i], ei[i]);
                end
                if (eg[i] >= 0) begin
                    n_checks++;
                    if (cap_gap[i] != eg[i]) begin
                        n_fail++;
                        $display("FAIL %s dwell[%0d]: idle %0d cycles, required %0d", name, i, cap_gap[i], eg[i]);
                    end
                end
            end
        end
        wait_cycles(8);
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (wr_go !== 1'b0 || wr_word !== 16'h0 || busy !== 1'b0 || ftw_cur !== 28'h0 ||
            step_idx !== 16'h0 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: go=%b word=%h busy=%b ftw=%h idx=%0d done=%b, required all zero",
                     name, wr_go, wr_word, busy, ftw_cur, step_idx, sweep_done);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        ftw_start = '0; ftw_step = '0; num_steps = '0; dwell_clks = '0;
        wait_cycles(3);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_start_stop_same;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || wr_go !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_same: busy=%b go=%b, required 0 0", busy, wr_go);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_basic;
        ack_min = 4; ack_max = 4;
        do_sweep(28'h0123456, 28'h10, 16'd3, 24'd5, 1'b0, 0, 0, 0, "basic");
        ack_min = 2; ack_max = 5;
    endtask

    task automatic test_zero_cfg;
        do_sweep(28'h00ABCDE, 28'h100, 16'd0, 24'd0, 1'b0, 0, 0, 0, "zero_cfg");
    endtask

    task automatic test_wrap;
        do_sweep(28'hFFFFFF8, 28'h10, 16'd2, 24'd3, 1'b0, 0, 0, 0, "wrap");
        n_checks++;
        if (cap_ftw.size() < 5 || cap_ftw[4] !== 28'h0000008) begin
            n_fail++;
            $display("FAIL wrap_point1: ftw=%h, required 0000008", cap_ftw.size() >= 5 ? cap_ftw[4] : 28'hx);
        end
    endtask

    task automatic test_stop;
        ack_min = 4; ack_max = 4;
        do_sweep(28'h0200000, 28'h40, 16'd4, 24'd4, 1'b0, 1, 3, 2, "stop_msw");
        ack_min = 2; ack_max = 5;
        do_sweep(28'h0300000, 28'h40, 16'd4, 24'd12, 1'b0, 2, 4, 0, "stop_dwell");
        do_sweep(28'h0310000, 28'h80, 16'd2, 24'd2, 1'b0, 1, 8, 0, "stop_finish");
    endtask

    task automatic test_continuous;
        do_sweep(28'h0456789, 28'h1000, 16'd2, 24'd3, 1'b1, 1, 9, 0, "continuous");
        n_checks++;
        if (cap_ftw.size() < 7 || cap_ftw[6] !== 28'h0456789) begin
            n_fail++;
            $display("FAIL continuous_restart: ftw=%h, required 0456789", cap_ftw.size() >= 7 ? cap_ftw[6] : 28'hx);
        end
    endtask

    task automatic test_reset_mid;
        int t;
        ftw_start = 28'h0777777; ftw_step = 28'h11; num_steps = 16'd3;
        dwell_clks = 24'd40; continuous = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (n_acked < 4 && t < 500) begin @(negedge clk); t++; end
        wait_cycles(3);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_dwell");
        wait_cycles(8);
        rst_n = 1'b1;
        wait_cycles(2);

        ack_min = 6; ack_max = 6;
        cap_word.delete(); cap_ftw.delete(); cap_idx.delete(); cap_gap.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (cap_word.size() < 2 && t < 500) begin @(negedge clk); t++; end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_transfer");
        wait_cycles(8);
        rst_n = 1'b1;
        ack_min = 2; ack_max = 5;
        wait_cycles(2);
        do_sweep(28'h0000100, 28'h3, 16'd2, 24'd2, 1'b0, 0, 0, 0, "after_reset");
    endtask

    task automatic test_random;
        logic [15:0] n;
        bit          c;
        int          sm, sk;
        for (int it = 0; it < 8; it++) begin
            n  = 16'($urandom_range(0, 4));
            c  = ($urandom_range(0, 3) == 0);
            sm = c ? 1 : $urandom_range(0, 1);
            sk = $urandom_range(1, 14);
            do_sweep(28'($urandom), 28'($urandom), n, 24'($urandom_range(0, 6)), c, sm, sk, 0, "random");
        end
    endtask

    initial begin
        test_reset;
        test_start_stop_same;
        test_basic;
        test_zero_cfg;
        test_wrap;
        test_stop;
        test_continuous;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
